// File: rtl/matrix_writer.sv
// matrix_writer: commits a parsed matrix (header word + row-major elements) into one BRAM slot.
// Define MATRIX_WRITER_ZERO_FILL_EN to zero-fill and commit on abort instead of leaving the slot invalid.
module matrix_writer #(
  parameter int BLOCK_SIZE = 1152,
  parameter int ADDR_WIDTH = 14,
  parameter int MAX_DIM    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            matrix_id,
  input  logic [7:0]            rows,
  input  logic [7:0]            cols,
  input  logic [31:0]           elem_data,
  input  logic                  elem_valid,
  output logic                  elem_ready,
  input  logic                  abort,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [31:0]           bram_din,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_WRITE_ELEM,
    ST_WRITE_HDR,
    ST_FILL
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] BLOCK_W   = ADDR_WIDTH'(BLOCK_SIZE);
  localparam logic [7:0]            MAX_DIM_W = 8'(MAX_DIM);
  localparam logic [15:0]           MAX_ELEMS = 16'(BLOCK_SIZE - 1);

  state_t                  state_q, state_d;
  logic [2:0]              id_q, id_d;
  logic [7:0]              rows_q, rows_d;
  logic [7:0]              cols_q, cols_d;
  logic [15:0]             count_q, count_d;
  logic                    we_q, we_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]             din_q, din_d;
  logic                    done_q, done_d;
  logic                    error_q, error_d;

  logic [15:0]             total;
  logic [ADDR_WIDTH-1:0]   base;
  logic [ADDR_WIDTH-1:0]   elem_addr;
  logic                    legal;
  logic                    last;

  assign total     = 16'(rows_q) * 16'(cols_q);
  assign base      = ADDR_WIDTH'(id_q) * BLOCK_W;
  assign elem_addr = base + ADDR_WIDTH'(count_q) + ADDR_WIDTH'(1);
  assign last      = (count_q == total - 16'd1);
  assign legal     = (rows_q != 8'd0) && (rows_q <= MAX_DIM_W) &&
                     (cols_q != 8'd0) && (cols_q <= MAX_DIM_W) &&
                     (total <= MAX_ELEMS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:       if (start) state_d = ST_CHECK;
      ST_CHECK:      state_d = legal ? ST_WRITE_ELEM : ST_IDLE;
      ST_WRITE_ELEM: begin
        if (abort) begin
`ifdef MATRIX_WRITER_ZERO_FILL_EN
          state_d = ST_FILL;
`else
          state_d = ST_IDLE;
`endif
        end else if (elem_valid && last) begin
          state_d = ST_WRITE_HDR;
        end
      end
      ST_FILL:       if (last) state_d = ST_WRITE_HDR;
      ST_WRITE_HDR:  state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  // Registered outputs are computed here one cycle ahead of where they appear.
  always_comb begin
    id_d    = id_q;
    rows_d  = rows_q;
    cols_d  = cols_q;
    count_d = count_q;
    we_d    = 1'b0;
    addr_d  = '0;
    din_d   = '0;
    done_d  = 1'b0;
    error_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          id_d    = matrix_id;
          rows_d  = rows;
          cols_d  = cols;
          count_d = '0;
        end
      end
      ST_CHECK: begin
        if (legal) begin
          we_d   = 1'b1;
          addr_d = base;
        end else begin
          error_d = 1'b1;
        end
      end
      ST_WRITE_ELEM: begin
        if (abort) begin
`ifndef MATRIX_WRITER_ZERO_FILL_EN
          error_d = 1'b1;
`endif
        end else if (elem_valid) begin
          we_d    = 1'b1;
          addr_d  = elem_addr;
          din_d   = elem_data;
          count_d = count_q + 16'd1;
        end
      end
      ST_FILL: begin
        we_d    = 1'b1;
        addr_d  = elem_addr;
        count_d = count_q + 16'd1;
      end
      ST_WRITE_HDR: begin
        we_d   = 1'b1;
        addr_d = base;
        din_d  = {16'd0, cols_q, rows_q};
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q    <= '0;
      rows_q  <= '0;
      cols_q  <= '0;
      count_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      id_q    <= id_d;
      rows_q  <= rows_d;
      cols_q  <= cols_d;
      count_q <= count_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      done_q  <= done_d;
      error_q <= error_d;
    end
  end

  assign elem_ready = (state_q == ST_WRITE_ELEM);
  assign busy       = (state_q != ST_IDLE);
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign done       = done_q;
  assign error      = error_q;

endmodule

// File: tb/tb_matrix_writer.sv
// tb_matrix_writer: random and directed matrices checked against a slot-level write-list model.
module tb_matrix_writer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  matrix_id;
  logic [7:0]  rows;
  logic [7:0]  cols;
  logic [31:0] elem_data;
  logic        elem_valid;
  logic        elem_ready;
  logic        abort;
  logic        bram_we;
  logic [13:0] bram_addr;
  logic [31:0] bram_din;
  logic        busy;
  logic        done;
  logic        error;

  matrix_writer dut (
    .clk(clk), .rst(rst), .start(start), .matrix_id(matrix_id), .rows(rows), .cols(cols),
    .elem_data(elem_data), .elem_valid(elem_valid), .elem_ready(elem_ready), .abort(abort),
    .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          got_addr[$];
  logic [31:0] got_data[$];
  int          done_cnt, err_cnt, both_cnt = 0;
  int          done_addr, err_cyc, start_cyc;
  logic        done_we;
  logic [31:0] vals[0:1023];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      got_addr.push_back(int'(bram_addr));
      got_data.push_back(bram_din);
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_we   = bram_we;
      done_addr = int'(bram_addr);
    end
    if (error === 1'b1) begin
      err_cnt++;
      err_cyc = cyc;
    end
    if (done === 1'b1 && error === 1'b1) both_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // vmode: 0 = always valid, 1 = valid pattern 1,0,0, 2 = random valid
  task automatic run_matrix(input string tag, input int id, input int r, input int c,
                            input int vmode, input int abort_at, input int rst_at,
                            input bit mid_start);
    int          n, k, base, hdr, to, m;
    bit          legal, aborted, acc, reset_hit, exp_done, exp_err;
    int          exp_addr[$];
    logic [31:0] exp_data[$];
    got_addr.delete();
    got_data.delete();
    done_cnt = 0; err_cnt = 0; done_we = 1'b0; done_addr = -1; err_cyc = 0;
    n     = r * c;
    legal = (r >= 1 && r <= 32 && c >= 1 && c <= 32 && n <= 1151);
    base  = id * 1152;
    hdr   = (c << 8) | r;

    @(posedge clk); #1;
    start = 1'b1; matrix_id = id[2:0]; rows = r[7:0]; cols = c[7:0];
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0; matrix_id = 3'($urandom); rows = 8'($urandom); cols = 8'($urandom);

    k = 0; aborted = 1'b0; reset_hit = 1'b0;
    if (legal) begin
      for (int t = 0; t < 20000 && k < n; t++) begin
        case (vmode)
          0:       elem_valid = 1'b1;
          1:       elem_valid = (t % 3 == 0);
          default: elem_valid = 1'($urandom_range(0, 1));
        endcase
        elem_data = vals[k];
        if (rst_at >= 0 && k == rst_at && elem_ready) begin
          reset_hit = 1'b1;
          break;
        end
        abort = (abort_at >= 0 && k == abort_at && elem_ready);
        if (abort) elem_valid = 1'b1;
        if (mid_start && k == 1 && elem_ready) begin
          start = 1'b1; matrix_id = ~id[2:0]; rows = 8'd5; cols = 8'd7;
        end
        acc = elem_valid && elem_ready && !abort;
        @(posedge clk); #1;
        start = 1'b0;
        if (abort) begin
          aborted = 1'b1;
          abort   = 1'b0;
          break;
        end
        if (acc) k++;
      end
      elem_valid = 1'b0;
    end

    if (reset_hit) begin
      @(negedge clk); #1;
      rst = 1'b1;
      #1;
      chk({tag, "_outs_in_rst"}, {bram_we, done, error, busy, elem_ready, bram_addr, bram_din}, '0);
      #2;
      rst = 1'b0;
      repeat (2) @(negedge clk);
    end else begin
      to = 0;
      while (done_cnt + err_cnt == 0 && to < 3000) begin
        @(negedge clk);
        to++;
      end
      chk({tag, "_timeout"}, 64'(to >= 3000), 0);
      repeat (3) @(negedge clk);
      chk({tag, "_idle_after"}, {busy, elem_ready}, 0);
    end

    exp_done = 1'b0; exp_err = 1'b0;
    if (legal) begin
      exp_addr.push_back(base); exp_data.push_back(32'd0);
      for (int i = 0; i < k; i++) begin
        exp_addr.push_back(base + 1 + i); exp_data.push_back(vals[i]);
      end
      if (reset_hit) begin
        exp_done = 1'b0;
      end else if (aborted) begin
`ifdef MATRIX_WRITER_ZERO_FILL_EN
        for (int i = k; i < n; i++) begin
          exp_addr.push_back(base + 1 + i); exp_data.push_back(32'd0);
        end
        exp_addr.push_back(base); exp_data.push_back(32'(hdr));
        exp_done = 1'b1;
`else
        exp_err = 1'b1;
`endif
      end else begin
        exp_addr.push_back(base); exp_data.push_back(32'(hdr));
        exp_done = 1'b1;
      end
    end else begin
      exp_err = 1'b1;
    end

    chk({tag, "_nwrites"}, 64'(got_addr.size()), 64'(exp_addr.size()));
    m = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
    for (int i = 0; i < m; i++) begin
      chk({tag, "_addr"}, 64'(got_addr[i]), 64'(exp_addr[i]));
      chk({tag, "_data"}, 64'(got_data[i]), 64'(exp_data[i]));
    end
    chk({tag, "_done_cnt"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, "_err_cnt"}, 64'(err_cnt), 64'(exp_err));
    if (exp_done) chk({tag, "_done_on_hdr"}, {31'd0, done_we, 32'(done_addr)}, {31'd0, 1'b1, 32'(base)});
    if (!legal)   chk({tag, "_err_timing"}, 64'(err_cyc - start_cyc), 64'd2);
  endtask

  initial begin
    int r, c, ab;
    rst = 1'b1; start = 1'b0; matrix_id = '0; rows = '0; cols = '0;
    elem_data = '0; elem_valid = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outs", {bram_we, done, error, busy, elem_ready, bram_addr, bram_din}, '0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) vals[i] = 32'(i + 1);
    run_matrix("basic", 1, 2, 3, 0, -1, -1, 1'b0);

    run_matrix("bad_r0", 0, 0, 4, 0, -1, -1, 1'b0);
    run_matrix("bad_r33", 3, 33, 4, 0, -1, -1, 1'b0);
    run_matrix("bad_c33", 6, 2, 33, 0, -1, -1, 1'b0);

    for (int i = 0; i < 9; i++) vals[i] = -32'(i + 1);
    run_matrix("backpressure", 4, 3, 3, 1, -1, -1, 1'b0);

    for (int i = 0; i < 1024; i++) vals[i] = $urandom;
    run_matrix("abort", 0, 2, 2, 0, 2, -1, 1'b0);
    run_matrix("abort_first", 5, 1, 3, 2, 0, -1, 1'b0);
    run_matrix("max", 7, 32, 32, 0, -1, -1, 1'b0);
    run_matrix("mid_start", 5, 4, 4, 2, -1, -1, 1'b1);
    run_matrix("rst_mid", 2, 3, 3, 0, -1, 4, 1'b0);
    run_matrix("post_rst", 2, 2, 2, 0, -1, -1, 1'b0);

    for (int j = 0; j < 12; j++) begin
      for (int i = 0; i < 1024; i++) vals[i] = $urandom;
      r  = ($urandom_range(0, 9) == 0) ? 33 : $urandom_range(0, 10);
      c  = $urandom_range(0, 10);
      ab = (r * c > 0 && $urandom_range(0, 2) == 0) ? $urandom_range(0, r * c - 1) : -1;
      run_matrix("rand", $urandom_range(0, 7), r, c, 2, ab, -1, 1'b0);
    end

    chk("done_error_exclusive", 64'(both_cnt), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
